mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS control unit that sequences the shared `execute` ALU, instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback steps. It sits beside the datapath, consumes the instruction opcode and the ALU `zero` flag, and drives every datapath enable and mux select. Memory accesses use a ready handshake so variable-latency memory stalls the sequence cleanly.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction register bits [31:26], valid from DECODE onward.
- `zero`  in  1  `zero` output of `execute`.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_en`  out  1  load the PC this cycle.
- `ir_write`  out  1  load the instruction register.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_read`, `mem_write`  out  1 each  memory request, held until `mem_ready`.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  destination select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data: 0 = ALU out, 1 = memory data.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = `AluReadData1`.
- `ALUSrc`  out  2  ALU B select: 0 = `AluReadData2`, 1 = constant 4, 2 = immediate, 3 = immediate<<2.
- `imm_zext`  out  1  immediate is zero-extended (ori); otherwise sign-extended.
- `ALUOp`  out  3  to `execute`: 0 add, 1 sub, 2 R-type (decode `funct`), 3 or.
- `pc_src`  out  2  next PC: 0 = ALU result, 1 = ALU out register, 2 = jump target.
- `state`  out  4  current state, for debug.
- `retired`  out  32  count of completed instructions.
- `halted`  out  1  illegal-opcode halt (see Configuration).

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, HALT=12.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `ALUSrc`=1, `ALUOp`=0, `pc_src`=0. `ir_write`=`pc_en`=`mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alu_src_a`=0, `ALUSrc`=3, `ALUOp`=0 (branch target precompute). Next state by `opcode`:
  - 000000 -> RTEX
  - 100011 (lw) and 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) and 001101 (ori) -> IMMEX
  - 000010 (j) -> JUMP
  - any other opcode: see Configuration.
- MEMADR: `alu_src_a`=1, `ALUSrc`=2, `ALUOp`=0. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
- MEMWR: `mem_write`=1, `iord`=1. Waits for `mem_ready`.
- RTEX: `alu_src_a`=1, `ALUSrc`=0, `ALUOp`=2. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
- BRANCH: `alu_src_a`=1, `ALUSrc`=0, `ALUOp`=1, `pc_src`=1, `pc_en`=`zero`.
- IMMEX: `alu_src_a`=1, `ALUSrc`=2. addi uses `ALUOp`=0, `imm_zext`=0; ori uses `ALUOp`=3, `imm_zext`=1. Goes to IMMWB.
- IMMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
- JUMP: `pc_src`=2, `pc_en`=1.
- Terminal states MEMWB, MEMWR (when `mem_ready`), ALUWB, BRANCH, IMMWB and JUMP all return to FETCH and increment `retired`. `retired` wraps from 0xFFFFFFFF to 0.
- Any output not listed for a state is 0.
- `mem_read` and `mem_write` are never both 1.

## Timing
- Outputs are Moore decodes of `state`, except `pc_en`/`ir_write` (gated by `mem_ready` or `zero` in the same cycle).
- Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3. Each `mem_ready`-low cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset (asynchronous, any state, including mid-MEMRD/MEMWR): `state`=FETCH, `retired`=0, `halted`=0.
- While `reset` is high, `pc_en`, `ir_write`, `reg_write` and `mem_write` are forced to 0. The other outputs take their FETCH values.
- The first fetch request is issued in the first cycle after `reset` deasserts.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an unknown opcode in DECODE goes to HALT.
  - HALT drives all enables to 0 and sets `halted`=1.
  - HALT is left only by reset. `retired` is not incremented.
- `CTRL_ILLEGAL_TRAP_EN` undefined: an unknown opcode is a NOP. DECODE goes to FETCH and `retired` increments. The HALT state and the `halted` logic are not built; `halted` is tied to 0.

## Test plan
- lw with `mem_ready` low 2 cycles in both FETCH and MEMRD -> 9 cycles; `reg_write`=1 with `mem_to_reg`=1 in MEMWB; `retired`=1.
- R-type (opcode 0) -> state sequence 0,1,6,7,0; `ALUOp`=2 in RTEX; `reg_dst`=1 in ALUWB.
- beq with `zero`=1, then beq with `zero`=0 -> `pc_en`=1 in BRANCH for the first only; both take 3 cycles.
- ori -> `ALUOp`=3, `imm_zext`=1, `ALUSrc`=2 in IMMEX; j -> `pc_src`=2, `pc_en`=1 in JUMP.
- Reset asserted mid-MEMWR -> `state`=0 and `mem_write`=0 immediately (asynchronous); `retired`=0.
- Opcode 111111 -> with the macro: `halted`=1, state 12 held for 10 cycles. Without the macro: back to FETCH and `retired` increments.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a memory ready handshake.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcode traps into a HALT state).
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  ALUSrc,
    output logic        imm_zext,
    output logic [2:0]  ALUOp,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic [31:0] retired,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire_s;

    // State and retired-instruction counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; retire_s marks the cycle an instruction completes
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_RTEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_IMMEX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: if (opcode == OP_SW) state_d = S_MEMWR; else state_d = S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else state_d = S_MEMRD;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_RTEX:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
        if (retire_s) retired_d = retired_q + 32'd1;
        else          retired_d = retired_q;
    end

    // Moore output decode; pc_en/ir_write additionally gated by mem_ready or zero
    always_comb begin
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        ALUSrc     = 2'd0;
        imm_zext   = 1'b0;
        ALUOp      = 3'd0;
        pc_src     = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrc   = 2'd1;
                pc_en    = mem_ready;
                ir_write = mem_ready;
            end
            S_DECODE: ALUSrc = 2'd3;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                ALUSrc    = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                ALUOp     = 3'd2;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ALUOp     = 3'd1;
                pc_src    = 2'd1;
                pc_en     = zero;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                ALUSrc    = 2'd2;
                if (opcode == OP_ORI) begin
                    ALUOp    = 3'd3;
                    imm_zext = 1'b1;
                end else begin
                    ALUOp    = 3'd0;
                    imm_zext = 1'b0;
                end
            end
            S_IMMWB:  reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'd2;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous, so writes must be suppressed combinationally too
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end else begin
            pc_en     = pc_en;
            ir_write  = ir_write;
            reg_write = reg_write;
            mem_write = mem_write;
        end
    end

    // Debug/status outputs
    always_comb begin
        state   = state_q;
        retired = retired_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        halted  = (state_q == S_HALT);
`else
        halted  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench: a per-instruction cycle plan built from opcode class and stall counts.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  ALUSrc;
    logic        imm_zext;
    logic [2:0]  ALUOp;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic [31:0] retired;
    logic        halted;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_retired = 32'd0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .ALUSrc(ALUSrc), .imm_zext(imm_zext), .ALUOp(ALUOp), .pc_src(pc_src), .state(state),
        .retired(retired), .halted(halted)
    );

    always #5 clk = ~clk;

    // Expected control word for a step: {pc_en,ir_write,iord,mem_read,mem_write,reg_write,reg_dst,
    // mem_to_reg,alu_src_a,ALUSrc,imm_zext,ALUOp,pc_src,halted}
    function automatic logic [17:0] exp_out(int st, logic [5:0] op, logic z, logic rdy);
        logic pe = 1'b0, irw = 1'b0, io = 1'b0, mr = 1'b0, mw = 1'b0, rw = 1'b0;
        logic rd = 1'b0, m2r = 1'b0, asa = 1'b0, zx = 1'b0, h = 1'b0;
        logic [1:0] asb = 2'd0, ps = 2'd0;
        logic [2:0] aop = 3'd0;
        case (st)
            0:  begin mr = 1'b1; asb = 2'd1; pe = rdy; irw = rdy; end
            1:  asb = 2'd3;
            2:  begin asa = 1'b1; asb = 2'd2; end
            3:  begin mr = 1'b1; io = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mw = 1'b1; io = 1'b1; end
            6:  begin asa = 1'b1; aop = 3'd2; end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin asa = 1'b1; aop = 3'd1; ps = 2'd1; pe = z; end
            9:  begin asa = 1'b1; asb = 2'd2;
                      if (op == 6'b001101) begin aop = 3'd3; zx = 1'b1; end end
            10: rw = 1'b1;
            11: begin ps = 2'd2; pe = 1'b1; end
            12: h = 1'b1;
            default: ;
        endcase
        return {pe, irw, io, mr, mw, rw, rd, m2r, asa, asb, zx, aop, ps, h};
    endfunction

    function automatic logic [17:0] act_out();
        return {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, ALUSrc, imm_zext, ALUOp, pc_src, halted};
    endfunction

    // Runs one instruction from FETCH back to FETCH. zmode: -1 random zero, else fixed.
    task automatic exec_instr(input logic [5:0] op, input int fst, input int mst, input int zmode,
                              input string tag);
        int   sts[$];
        logic rdys[$];
        logic z;
        for (int i = 0; i < fst; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
        sts.push_back(0); rdys.push_back(1'b1);
        sts.push_back(1); rdys.push_back(1'($urandom));
        case (op)
            6'b100011: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                for (int i = 0; i < mst; i++) begin sts.push_back(3); rdys.push_back(1'b0); end
                sts.push_back(3); rdys.push_back(1'b1);
                sts.push_back(4); rdys.push_back(1'($urandom));
            end
            6'b101011: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                for (int i = 0; i < mst; i++) begin sts.push_back(5); rdys.push_back(1'b0); end
                sts.push_back(5); rdys.push_back(1'b1);
            end
            6'b000000: begin sts.push_back(6); rdys.push_back(1'($urandom));
                             sts.push_back(7); rdys.push_back(1'($urandom)); end
            6'b000100: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
            6'b001000, 6'b001101: begin
                sts.push_back(9);  rdys.push_back(1'($urandom));
                sts.push_back(10); rdys.push_back(1'($urandom));
            end
            6'b000010: begin sts.push_back(11); rdys.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            opcode = op; mem_ready = rdys[i]; zero = z;
            #1;
            n_tests++;
            if (state !== 4'(sts[i])) begin
                n_fail++;
                $display("FAIL %s state step %0d: got %0d want %0d", tag, i, state, sts[i]);
            end
            n_tests++;
            if (act_out() !== exp_out(sts[i], op, z, rdys[i])) begin
                n_fail++;
                $display("FAIL %s outputs step %0d (state %0d): got %b want %b", tag, i, sts[i],
                         act_out(), exp_out(sts[i], op, z, rdys[i]));
            end
            @(posedge clk); #1;
        end
        exp_retired = exp_retired + 32'd1;
        n_tests++;
        if (state !== 4'd0 || retired !== exp_retired) begin
            n_fail++;
            $display("FAIL %s end: state %0d retired %0d want state 0 retired %0d", tag, state,
                     retired, exp_retired);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (state !== 4'd0 || retired !== 32'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state %0d retired %0d halted %b", state, retired, halted);
        end
        n_tests++;
        if ({pc_en, ir_write, reg_write, mem_write, mem_read, ALUSrc} !== {4'b0000, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b",
                     {pc_en, ir_write, reg_write, mem_write, mem_read, ALUSrc}, 7'b0000101);
        end
        reset = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_lw_stall();
        exec_instr(6'b100011, 2, 2, -1, "lw_stall");
    endtask

    task automatic test_rtype();
        exec_instr(6'b000000, 0, 0, -1, "rtype");
    endtask

    task automatic test_beq();
        exec_instr(6'b000100, 0, 0, 1, "beq_taken");
        exec_instr(6'b000100, 0, 0, 0, "beq_not_taken");
    endtask

    task automatic test_ori_j();
        exec_instr(6'b001101, 0, 0, -1, "ori");
        exec_instr(6'b001000, 1, 0, -1, "addi");
        exec_instr(6'b000010, 0, 0, -1, "jump");
        exec_instr(6'b101011, 0, 3, -1, "sw_stall");
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        opcode = 6'b111111; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom); zero = 1'($urandom);
            #1;
            n_tests++;
            if (state !== 4'd12 || act_out() !== exp_out(12, opcode, zero, mem_ready)
                || retired !== exp_retired) begin
                n_fail++;
                $display("FAIL halt cycle %0d: state %0d out %b retired %0d", i, state, act_out(), retired);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; #1; reset = 1'b0;
        exp_retired = 32'd0;
        @(posedge clk); #1;
`else
        exec_instr(6'b111111, 0, 0, -1, "illegal_nop");
        exec_instr(6'b010101, 1, 0, -1, "illegal_nop2");
`endif
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        int n_ops;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
        ops[4] = 6'b001000; ops[5] = 6'b001101; ops[6] = 6'b000010;
`ifdef CTRL_ILLEGAL_TRAP_EN
        n_ops = 7;
`else
        n_ops = 8;
`endif
        for (int k = 0; k < 40; k++) begin
            int idx;
            logic [5:0] op;
            idx = int'($urandom_range(n_ops - 1, 0));
            op  = (idx == 7) ? 6'b110011 : ops[idx];
            exec_instr(op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), -1, "random");
        end
    endtask

    task automatic test_reset_mid_memwr();
        opcode = 6'b101011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL memwr_entry: state %0d mem_write %b want 5/1", state, mem_write);
        end
        mem_ready = 1'b1; reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || mem_write !== 1'b0 || pc_en !== 1'b0 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: state %0d mem_write %b pc_en %b retired %0d want 0/0/0/0",
                     state, mem_write, pc_en, retired);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 32'd0;
        exec_instr(6'b000000, 0, 0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_rtype();
        test_beq();
        test_ori_j();
        test_illegal();
        test_random();
        test_reset_mid_memwr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
